// File: rtl/mult_unit_pkg.sv
// Shared types and defaults for the iterative shift-add multiplier.
package mult_unit_pkg;

    localparam int unsigned DefWidth    = 32;
    localparam int unsigned DefStepBits = 1;

    // Fixed 2-bit encodings so state codes stay stable in waveforms and traces.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } mult_state_e;

    // Bits needed to count iterations 0..k-1 (at least one bit).
    function automatic int unsigned iter_width(input int unsigned k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/mult_unit_if.sv
// Pipeline <-> multiplier handshake: operands and control in, stall/result out.
interface mult_unit_if
    import mult_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             hold;
    logic             flush;
    logic             stall_req;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    // Pipeline side.
    modport master (
        output start, signed_op, op_a, op_b, hold, flush,
        input  stall_req, busy, done, lo, hi
    );

    // Multiplier side.
    modport slave (
        input  start, signed_op, op_a, op_b, hold, flush,
        output stall_req, busy, done, lo, hi
    );
endinterface

// File: rtl/mult_step.sv
// One shift-add step: acc + (|a| * b_slice) << (iter * STEP_BITS). Purely combinational.
module mult_step
    import mult_unit_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned STEP_BITS = DefStepBits,
    parameter int unsigned ITER_W    = 5
) (
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [STEP_BITS-1:0] b_slice,
    input  logic [ITER_W-1:0]    iter,
    output logic [2*WIDTH-1:0]   acc_next
);
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned ShW = $clog2(PW) + 1;

    logic [PW-1:0]  partial;
    logic [ShW-1:0] shamt;

    // Unsigned partial product on magnitudes, aligned to the current digit.
    always_comb begin
        partial  = PW'(a_mag) * PW'(b_slice);
        shamt    = ShW'(iter) * ShW'(STEP_BITS);
        acc_next = acc + (partial << shamt);
    end
endmodule

// File: rtl/mult_unit.sv
// Iterative shift-add WIDTHxWIDTH multiplier for the EXE stage.
// Holds the pipeline (stall_req) while a product is being formed.
// Optional: define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier is zero.
module mult_unit
    import mult_unit_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned STEP_BITS = DefStepBits
) (
    input  logic       clk,
    input  logic       rst,
    mult_unit_if.slave bus
);
    localparam int unsigned K      = WIDTH / STEP_BITS;
    localparam int unsigned ITER_W = iter_width(K);
    localparam int unsigned PW     = 2 * WIDTH;

    mult_state_e       state_q;
    logic [WIDTH-1:0]  a_mag_q;
    logic [WIDTH-1:0]  b_q;
    logic              neg_q;
    logic [PW-1:0]     acc_q;
    logic [ITER_W-1:0] iter_q;
    logic [WIDTH-1:0]  lo_q;
    logic [WIDTH-1:0]  hi_q;

    logic [PW-1:0]     step_acc;
    logic [PW-1:0]     acc_fix;
    logic [WIDTH-1:0]  b_shift;
    logic [WIDTH-1:0]  a_mag_in;
    logic [WIDTH-1:0]  b_mag_in;
    logic              neg_in;
    logic              last;

    mult_step #(
        .WIDTH     (WIDTH),
        .STEP_BITS (STEP_BITS),
        .ITER_W    (ITER_W)
    ) u_step (
        .acc      (acc_q),
        .a_mag    (a_mag_q),
        .b_slice  (b_q[STEP_BITS-1:0]),
        .iter     (iter_q),
        .acc_next (step_acc)
    );

    // Operand magnitudes and result sign captured on accept; most-negative maps to 2^(WIDTH-1).
    always_comb begin
        a_mag_in = (bus.signed_op && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
        b_mag_in = (bus.signed_op && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
        neg_in   = (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]) & bus.signed_op;
        b_shift  = b_q >> STEP_BITS;
        acc_fix  = neg_q ? -step_acc : step_acc;
`ifdef MULT_EARLY_TERM_EN
        last     = (iter_q == ITER_W'(K - 1)) || (b_shift == '0);
`else
        last     = (iter_q == ITER_W'(K - 1));
`endif
    end

    // FSM plus datapath registers; lo/hi load only on the BUSY->DONE step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_mag_q <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            iter_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start && !bus.flush) begin
                        a_mag_q <= a_mag_in;
                        b_q     <= b_mag_in;
                        neg_q   <= neg_in;
                        acc_q   <= '0;
                        iter_q  <= '0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (bus.flush) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q  <= step_acc;
                        b_q    <= b_shift;
                        iter_q <= iter_q + ITER_W'(1);
                        if (last) begin
                            {hi_q, lo_q} <= acc_fix;
                            state_q      <= StDone;
                        end
                    end
                end
                StDone: begin
                    // start here is the same instruction still sitting in EXE.
                    if (bus.flush || !bus.hold) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy      = (state_q == StBusy);
    assign bus.done      = (state_q == StDone);
    assign bus.lo        = lo_q;
    assign bus.hi        = hi_q;
    // Low in DONE so the pipeline advances in exactly the done cycle.
    assign bus.stall_req = ((state_q == StIdle) && bus.start && !bus.flush) ||
                           (state_q == StBusy);
endmodule

// File: tb/tb_mult_unit.sv
// Directed-vector bench for mult_unit: products, latency, stall, hold, flush, reset.
module tb_mult_unit;
    import mult_unit_pkg::*;

`ifdef MULT_EARLY_TERM_EN
    localparam bit EarlyTerm = 1'b1;
`else
    localparam bit EarlyTerm = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mult_unit_if #(.WIDTH(32)) bus ();

    mult_unit #(
        .WIDTH     (32),
        .STEP_BITS (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          sgn;
        logic [63:0] p;
        int          hold;
        bit          chain;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected busy cycles: 32, or msb_index(|b|)+1 (min 1) with early termination.
    function automatic int exp_busy(input logic [31:0] b, input bit sgn);
        logic [31:0] m;
        int          n;
        m = (sgn && b[31]) ? -b : b;
        n = 1;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) n = i + 1;
        end
        return EarlyTerm ? n : 32;
    endfunction

    task automatic do_mul(input vec_t v, input string tag);
        int cyc;
        int stalls;
        int lat;
        lat = exp_busy(v.b, v.sgn);
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.signed_op = v.sgn;
        bus.op_a      = v.a;
        bus.op_b      = v.b;
        @(negedge clk);
        check({tag, ".stall0"}, 64'(bus.stall_req), 64'd1);
        stalls = 1;
        cyc    = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            cyc = i;
            if (bus.done) break;
            if (bus.stall_req) stalls++;
        end
        check({tag, ".lat"}, 64'(cyc), 64'(lat + 1));
        check({tag, ".stalls"}, 64'(stalls), 64'(lat + 1));
        check({tag, ".prod"}, {bus.hi, bus.lo}, v.p);
        check({tag, ".stall_done"}, 64'(bus.stall_req), 64'd0);
        // start stays high through DONE: the same instruction must not re-issue.
        for (int h = 0; h < v.hold; h++) begin
            bus.hold = 1'b1;
            @(posedge clk);
            #1;
            @(negedge clk);
            check({tag, ".hold_done"}, 64'(bus.done), 64'd1);
            check({tag, ".hold_prod"}, {bus.hi, bus.lo}, v.p);
            check({tag, ".hold_stall"}, 64'(bus.stall_req), 64'd0);
        end
        bus.hold = 1'b0;
        if (!v.chain) begin
            bus.start = 1'b0;
            @(posedge clk);
            #1;
            @(negedge clk);
            check({tag, ".idle"}, {62'd0, bus.done, bus.busy}, 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        logic [63:0] prior;
        bit          done_seen;

        n_vec = 0;
        n_err = 0;
        vecs[0] = '{32'd7,        32'd6,        1'b0, 64'd42,                  0, 1'b0};
        vecs[1] = '{32'hFFFFFFFD, 32'd5,        1'b1, 64'hFFFFFFFF_FFFFFFF1,   0, 1'b0};
        vecs[2] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000,  0, 1'b1};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001,   0, 1'b0};
        vecs[4] = '{32'd9,        32'd2,        1'b0, 64'd18,                  0, 1'b0};
        vecs[5] = '{32'd12345,    32'd0,        1'b0, 64'd0,                   0, 1'b0};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1,                   0, 1'b0};
        vecs[7] = '{32'hFFFFFFFF, 32'd2,        1'b0, 64'h00000001_FFFFFFFE,   0, 1'b0};
        vecs[8] = '{32'h00010000, 32'h00010000, 1'b0, 64'h00000001_00000000,   3, 1'b0};
        vecs[9] = '{32'd7,        32'hFFFFFFFA, 1'b1, 64'hFFFFFFFF_FFFFFFD6,   0, 1'b0};

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.hold      = 1'b0;
        bus.flush     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.state", {61'd0, bus.stall_req, bus.done, bus.busy}, 64'd0);
        check("rst.prod", {bus.hi, bus.lo}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_mul(vecs[i], $sformatf("v%0d", i));
        end
        prior = vecs[9].p;

        // Flush at busy iteration 10 (cycle 11 after accept).
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.op_a      = 32'h1234;
        bus.op_b      = 32'h5678;
        repeat (11) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check("flush.busy_at", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush.idle", {62'd0, bus.stall_req, bus.busy}, 64'd0);
        check("flush.prod", {bus.hi, bus.lo}, prior);
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) done_seen = 1'b1;
        end
        check("flush.no_done", 64'(done_seen), 64'd0);

        // Asynchronous reset at busy iteration 5.
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op_a  = 32'h1111;
        bus.op_b  = 32'h2222;
        repeat (6) @(posedge clk);
        #2;
        check("rst_mid.busy_before", 64'(bus.busy), 64'd1);
        rst       = 1'b1;
        bus.start = 1'b0;
        #1;
        check("rst_mid.state", {61'd0, bus.stall_req, bus.done, bus.busy}, 64'd0);
        check("rst_mid.prod", {bus.hi, bus.lo}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        v = '{32'd5, 32'd5, 1'b0, 64'd25, 0, 1'b0};
        do_mul(v, "recover");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
